// File: rtl/bit_stream_packer.sv
// ---------------------------------------------------------------------------
// bit_stream_packer
//
// Purpose:
//    Collects a one-bit-per-beat serial stream into WIDTH-bit words using
//    streaming-concatenation ordering. Mode 0 places the first received bit
//    at the MSB. Mode 1 reverses the order of SLICE-bit slices, with slices
//    cut starting from the last-received end. Words cut short by in_last are
//    left-justified and zero padded.
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    mode       ordering select, sampled on the first bit of each word
//    in_valid   input beat valid
//    in_bit     serial data bit
//    in_last    final bit of a stream, closes the current word
//    in_ready   beat accepted when in_valid & in_ready
//    out_valid  packed word valid
//    out_ready  consumer accepts when out_valid & out_ready
//    out_data   packed word, left-justified
//    out_count  number of meaningful bits in out_data (1..WIDTH)
// ---------------------------------------------------------------------------
module bit_stream_packer #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode,
   input  logic                       in_valid,
   input  logic                       in_bit,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(WIDTH+1)-1:0] out_count
);

   localparam int CW = $clog2(WIDTH+1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             word_mode_q, word_mode_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CW-1:0]    out_count_q, out_count_d;

   logic             accept;
   logic             close_word;
   logic             cur_mode;
   logic [WIDTH-1:0] stream;
   logic [CW-1:0]    n_bits;
   logic [WIDTH-1:0] formatted;
   int               n_int;
   int               dest;
   int               slice_idx;
   int               slice_off;

   // Handshake and per-beat control. A closing beat is the only one that
   // needs room in the output register, so non-closing beats never stall.
   // The mode used for a beat is the live input on the first bit of a word
   // and the latched copy afterwards.
   always_comb begin
      in_ready   = !out_valid_q | out_ready | ((cnt_q != LAST_IDX) & !in_last);
      accept     = in_valid & in_ready;
      close_word = accept & ((cnt_q == LAST_IDX) | in_last);
      cur_mode   = (cnt_q == '0) ? mode : word_mode_q;
      stream     = {acc_q[WIDTH-2:0], in_bit};
      n_bits     = cnt_q + CW'(1);
   end

   // Word formatting. stream[n-1:0] holds the mode-0 value with the first
   // bit at position n-1. In mode 1, slice k covers stream bits
   // [k*SLICE +: SLICE]; full slices land from the MSB downward in order of
   // k, and the final short slice (earliest bits) lands at the bottom. The
   // n-bit result is then shifted up to the top of the word.
   always_comb begin
      formatted = '0;
      n_int     = int'(n_bits);
      dest      = 0;
      slice_idx = 0;
      slice_off = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < n_int) begin
            dest = i;
            if (cur_mode) begin
               slice_idx = i / SLICE;
               slice_off = i % SLICE;
               if ((slice_idx + 1) * SLICE <= n_int) begin
                  dest = n_int - (slice_idx + 1) * SLICE + slice_off;
               end else begin
                  dest = slice_off;
               end
            end
            formatted[IW'(WIDTH - n_int + dest)] = stream[IW'(i)];
         end
      end
   end

   // Next-state logic. A consume clears out_valid unless a new word closes
   // in the same cycle, in which case the register reloads without a bubble.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      word_mode_d = word_mode_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         word_mode_d = cur_mode;
         if (close_word) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = formatted;
            out_count_d = n_bits;
         end else begin
            acc_d = stream;
            cnt_d = n_bits;
         end
      end
   end

   // State registers; reset discards any partial word and any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         word_mode_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         word_mode_q <= word_mode_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule
